// File: rtl/mips_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_seq_pkg                                                 |
// | Description : Shared types and constants for the pipe_MIPS32 self-check    |
// |               sequencer (state encoding, counter widths, register-init     |
// |               depth).                                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_seq_pkg;

    // Sequencer state encoding. The top FSM uses IDLE/RINIT/LOAD/RUN/CHECK/DONE.
    // The checker sub-FSM reuses IDLE and owns CHK_REQ/CHK_CMP.
    typedef logic [2:0] seq_state_t;

    localparam seq_state_t S_IDLE    = 3'd0;
    localparam seq_state_t S_RINIT   = 3'd1;
    localparam seq_state_t S_LOAD    = 3'd2;
    localparam seq_state_t S_RUN     = 3'd3;
    localparam seq_state_t S_CHECK   = 3'd4;
    localparam seq_state_t S_DONE    = 3'd5;
    localparam seq_state_t S_CHK_REQ = 3'd6;
    localparam seq_state_t S_CHK_CMP = 3'd7;

    // Register-file preload: Reg[k]=k for k=0..30.
    localparam int NUM_REG_INIT = 31;
    localparam int REG_ADDR_W   = 5;

    // Saturating result counters.
    localparam int FAIL_CNT_W = 8;
    localparam int RUN_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/mips_seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_seq_checker                                             |
// | Description : Result read-back and compare engine. On i_start_chk it walks |
// |               the check table: one read request cycle (CHK_REQ) followed   |
// |               by one compare cycle (CHK_CMP) per entry. Counts mismatches  |
// |               (saturating) and captures the first mismatching address.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk1, rst_n        clock, asynchronous active-low reset                  |
// |   i_clr              clear result counters (new sequence accepted)         |
// |   i_start_chk        begin checking from index 0 (accepted when idle)      |
// |   i_chk_addr/expect  check-table entry for o_chk_idx                       |
// |   i_mem_rdata        memory read data, valid the cycle after o_chk_re      |
// |   o_chk_idx          check-table index                                     |
// |   o_chk_re           memory read strobe                                    |
// |   o_chk_done         high in the final compare cycle                       |
// |   o_fail_count       mismatch count, saturating                            |
// |   o_first_fail_addr  address of first mismatch, 0 if none                  |
// +----------------------------------------------------------------------------+
module mips_seq_checker
    import mips_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int CHECK_WORDS = 2
) (
    input  logic                          clk1,
    input  logic                          rst_n,
    input  logic                          i_clr,
    input  logic                          i_start_chk,
    input  logic [ADDR_W-1:0]             i_chk_addr,
    input  logic [DATA_W-1:0]             i_chk_expect,
    input  logic [DATA_W-1:0]             i_mem_rdata,
    output logic [$clog2(CHECK_WORDS):0]  o_chk_idx,
    output logic                          o_chk_re,
    output logic                          o_chk_done,
    output logic [FAIL_CNT_W-1:0]         o_fail_count,
    output logic [ADDR_W-1:0]             o_first_fail_addr
);

    localparam int                    c_IDX_W    = $clog2(CHECK_WORDS) + 1;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX = c_IDX_W'(CHECK_WORDS - 1);
    localparam logic [FAIL_CNT_W-1:0] c_FAIL_MAX = '1;

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [FAIL_CNT_W-1:0]   r_fail_count;
    logic [ADDR_W-1:0]       r_first_fail;
    logic                    w_last;
    logic                    w_mismatch;

    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_mismatch = (i_mem_rdata != i_chk_expect);

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start_chk) w_state_nxt = S_CHK_REQ;
            S_CHK_REQ: w_state_nxt = S_CHK_CMP;
            S_CHK_CMP: w_state_nxt = w_last ? S_IDLE : S_CHK_REQ;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_chk_re   = (r_state == S_CHK_REQ);
        o_chk_done = (r_state == S_CHK_CMP) && w_last;
    end

    // Index, mismatch counter and first-failure capture
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_fail_count <= '0;
            r_first_fail <= '0;
        end else begin
            if (i_clr) begin
                r_fail_count <= '0;
                r_first_fail <= '0;
            end
            if (i_start_chk && (r_state == S_IDLE)) begin
                r_idx <= '0;
            end
            if (r_state == S_CHK_CMP) begin
                // Index stays on the last entry once the table is exhausted.
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
                if (w_mismatch) begin
                    if (r_fail_count != c_FAIL_MAX) begin
                        r_fail_count <= r_fail_count + 1'b1;
                    end
                    if (r_fail_count == '0) begin
                        r_first_fail <= i_chk_addr;
                    end
                end
            end
        end
    end

    assign o_chk_idx         = r_idx;
    assign o_fail_count      = r_fail_count;
    assign o_first_fail_addr = r_first_fail;

endmodule
`default_nettype wire

// File: rtl/mips_prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_prog_sequencer                                          |
// | Description : Self-check sequencer for the pipe_MIPS32 core. Loads a       |
// |               program/data image into core memory, releases the core,      |
// |               waits for HLT (or times out), then reads back and compares   |
// |               result words against an expected-value table.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Optional feature macro: MIPS_SEQ_REG_INIT_EN                               |
// |   When defined, a RINIT phase writes Reg[k]=k (k=0..30) through            |
// |   reg_we/reg_addr/reg_wdata before the memory image is loaded.            |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk1, rst_n             clock, asynchronous active-low reset             |
// |   start                   one-cycle pulse, accepted in IDLE or DONE        |
// |   img_idx/addr/data       program image table lookup (combinational)       |
// |   chk_idx/addr/expect     check table lookup (combinational)               |
// |   mem_we/re/addr/wdata    core memory port (sequencer-owned when !cpu_run) |
// |   mem_rdata               read data, one cycle after mem_re                |
// |   cpu_run, cpu_halted     core run enable, core HALTED flag                |
// |   busy, done, pass        sequence status                                  |
// |   timeout                 run exceeded TIMEOUT_CYC                         |
// |   fail_count              mismatches, saturating at 255                    |
// |   first_fail_addr         first mismatching address                        |
// |   run_cycles              cycles spent in RUN, saturating                  |
// |   reg_we/addr/wdata       register preload (MIPS_SEQ_REG_INIT_EN only)     |
// +----------------------------------------------------------------------------+
module mips_prog_sequencer
    import mips_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int PROG_WORDS  = 8,
    parameter int CHECK_WORDS = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                          clk1,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [$clog2(PROG_WORDS):0]   img_idx,
    input  logic [ADDR_W-1:0]             img_addr,
    input  logic [DATA_W-1:0]             img_data,
    output logic [$clog2(CHECK_WORDS):0]  chk_idx,
    input  logic [ADDR_W-1:0]             chk_addr,
    input  logic [DATA_W-1:0]             chk_expect,
    output logic                          mem_we,
    output logic                          mem_re,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          cpu_run,
    input  logic                          cpu_halted,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [FAIL_CNT_W-1:0]         fail_count,
    output logic [ADDR_W-1:0]             first_fail_addr,
    output logic [RUN_CNT_W-1:0]          run_cycles
`ifdef MIPS_SEQ_REG_INIT_EN
    ,
    output logic                          reg_we,
    output logic [REG_ADDR_W-1:0]         reg_addr,
    output logic [DATA_W-1:0]             reg_wdata
`endif
);

    localparam int                     c_IMG_IDX_W = $clog2(PROG_WORDS) + 1;
    localparam logic [c_IMG_IDX_W-1:0] c_IMG_LAST  = c_IMG_IDX_W'(PROG_WORDS - 1);
    // Dedicated timeout counter so the limit is independent of the
    // 16-bit saturating run_cycles report.
    localparam int                     c_TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TMO_W-1:0]     c_TMO_LIMIT = c_TMO_W'(TIMEOUT_CYC);
    localparam logic [RUN_CNT_W-1:0]   c_RUN_MAX   = '1;

    seq_state_t                r_state;
    seq_state_t                w_state_nxt;
    logic [c_IMG_IDX_W-1:0]    r_img_idx;
    logic [c_TMO_W-1:0]        r_tmo_cnt;
    logic [c_TMO_W-1:0]        w_tmo_nxt;
    logic [RUN_CNT_W-1:0]      r_run_cycles;
    logic                      r_timeout;
    logic                      w_start_acc;
    logic                      w_img_last;
    logic                      w_tmo_hit;
    logic                      w_start_chk;
    logic                      w_chk_re;
    logic                      w_chk_done;

`ifdef MIPS_SEQ_REG_INIT_EN
    localparam logic [REG_ADDR_W-1:0] c_REG_LAST = REG_ADDR_W'(NUM_REG_INIT - 1);
    logic [REG_ADDR_W-1:0]     r_reg_k;
`endif

    assign w_start_acc = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_img_last  = (r_img_idx == c_IMG_LAST);
    assign w_tmo_nxt   = r_tmo_cnt + 1'b1;
    assign w_tmo_hit   = (w_tmo_nxt == c_TMO_LIMIT);
    // Halt takes priority over a coincident timeout.
    assign w_start_chk = (r_state == S_RUN) && cpu_halted;

    // State register
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_acc) begin
`ifdef MIPS_SEQ_REG_INIT_EN
                    w_state_nxt = S_RINIT;
`else
                    w_state_nxt = S_LOAD;
`endif
                end
            end
`ifdef MIPS_SEQ_REG_INIT_EN
            S_RINIT: if (r_reg_k == c_REG_LAST) w_state_nxt = S_LOAD;
`endif
            S_LOAD: if (w_img_last) w_state_nxt = S_RUN;
            S_RUN: begin
                if (cpu_halted) begin
                    w_state_nxt = S_CHECK;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_CHECK: if (w_chk_done) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_run   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
`ifdef MIPS_SEQ_REG_INIT_EN
        reg_we    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
`endif
        case (r_state)
`ifdef MIPS_SEQ_REG_INIT_EN
            S_RINIT: begin
                busy      = 1'b1;
                reg_we    = 1'b1;
                reg_addr  = r_reg_k;
                reg_wdata = DATA_W'(r_reg_k);
            end
`endif
            S_LOAD: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = img_addr;
                mem_wdata = img_data;
            end
            S_RUN: begin
                busy    = 1'b1;
                cpu_run = 1'b1;
            end
            S_CHECK: begin
                busy   = 1'b1;
                mem_re = w_chk_re;
                if (w_chk_re) begin
                    mem_addr = chk_addr;
                end
            end
            S_DONE: begin
                done = 1'b1;
                pass = (fail_count == '0) && !r_timeout;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Load index, run/timeout counters
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_img_idx    <= '0;
            r_tmo_cnt    <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_img_idx    <= '0;
                r_tmo_cnt    <= '0;
                r_run_cycles <= '0;
                r_timeout    <= 1'b0;
            end
            // Index stays on the last image word after LOAD completes.
            if ((r_state == S_LOAD) && !w_img_last) begin
                r_img_idx <= r_img_idx + 1'b1;
            end
            if (r_state == S_RUN) begin
                r_tmo_cnt <= w_tmo_nxt;
                if (r_run_cycles != c_RUN_MAX) begin
                    r_run_cycles <= r_run_cycles + 1'b1;
                end
                if (!cpu_halted && w_tmo_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

`ifdef MIPS_SEQ_REG_INIT_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_k <= '0;
        end else if (w_start_acc) begin
            r_reg_k <= '0;
        end else if ((r_state == S_RINIT) && (r_reg_k != c_REG_LAST)) begin
            r_reg_k <= r_reg_k + 1'b1;
        end
    end
`endif

    mips_seq_checker #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .CHECK_WORDS (CHECK_WORDS)
    ) u_checker (
        .clk1              (clk1),
        .rst_n             (rst_n),
        .i_clr             (w_start_acc),
        .i_start_chk       (w_start_chk),
        .i_chk_addr        (chk_addr),
        .i_chk_expect      (chk_expect),
        .i_mem_rdata       (mem_rdata),
        .o_chk_idx         (chk_idx),
        .o_chk_re          (w_chk_re),
        .o_chk_done        (w_chk_done),
        .o_fail_count      (fail_count),
        .o_first_fail_addr (first_fail_addr)
    );

    assign img_idx    = r_img_idx;
    assign timeout    = r_timeout;
    assign run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mips_prog_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_prog_sequencer                                       |
// | Description : Self-checking bench for mips_prog_sequencer. Provides the    |
// |               image/check ROMs, a word memory and an abstract core that    |
// |               executes the test program's net effect (Mem[121] =           |
// |               Mem[120] + 45) and raises HALTED after a chosen delay.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips_prog_sequencer;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 10;
    localparam int PROG_WORDS  = 9;
    localparam int CHECK_WORDS = 2;
    localparam int TIMEOUT_CYC = 50;
`ifdef MIPS_SEQ_REG_INIT_EN
    localparam int c_RINIT = 31;
`else
    localparam int c_RINIT = 0;
`endif

    logic                         clk1 = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         start = 1'b0;
    logic [$clog2(PROG_WORDS):0]  img_idx;
    logic [ADDR_W-1:0]            img_addr;
    logic [DATA_W-1:0]            img_data;
    logic [$clog2(CHECK_WORDS):0] chk_idx;
    logic [ADDR_W-1:0]            chk_addr;
    logic [DATA_W-1:0]            chk_expect;
    logic                         mem_we, mem_re;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [DATA_W-1:0]            mem_rdata = '0;
    logic                         cpu_run;
    logic                         cpu_halted = 1'b0;
    logic                         busy, done, pass, timeout;
    logic [7:0]                   fail_count;
    logic [ADDR_W-1:0]            first_fail_addr;
    logic [15:0]                  run_cycles;
`ifdef MIPS_SEQ_REG_INIT_EN
    logic                         reg_we;
    logic [4:0]                   reg_addr;
    logic [DATA_W-1:0]            reg_wdata;
`endif

    mips_prog_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_WORDS(PROG_WORDS),
        .CHECK_WORDS(CHECK_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start),
        .img_idx(img_idx), .img_addr(img_addr), .img_data(img_data),
        .chk_idx(chk_idx), .chk_addr(chk_addr), .chk_expect(chk_expect),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_count(fail_count), .first_fail_addr(first_fail_addr),
        .run_cycles(run_cycles)
`ifdef MIPS_SEQ_REG_INIT_EN
        , .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata)
`endif
    );

    always #5 clk1 = ~clk1;

    // Image and check ROMs
    logic [ADDR_W-1:0] img_addr_tbl [PROG_WORDS];
    logic [DATA_W-1:0] img_data_tbl [PROG_WORDS];
    logic [ADDR_W-1:0] chk_addr_tbl [CHECK_WORDS];
    logic [DATA_W-1:0] chk_exp_tbl  [CHECK_WORDS];

    always_comb begin
        int ii;
        int ci;
        ii = int'(img_idx);
        ci = int'(chk_idx);
        img_addr   = '0;
        img_data   = '0;
        chk_addr   = '0;
        chk_expect = '0;
        if (ii < PROG_WORDS) begin
            img_addr = img_addr_tbl[ii];
            img_data = img_data_tbl[ii];
        end
        if (ci < CHECK_WORDS) begin
            chk_addr   = chk_addr_tbl[ci];
            chk_expect = chk_exp_tbl[ci];
        end
    end

    // Memory, abstract core and strobe monitors
    logic [DATA_W-1:0] mem [1024];
    int  core_cnt = 0;
    bit  halt_en = 1'b0;
    int  halt_after = 0;
    int  we_cnt = 0, re_cnt = 0, both_cnt = 0;

    always @(posedge clk1) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (!cpu_run) begin
            core_cnt   <= 0;
            cpu_halted <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            if (halt_en && (core_cnt + 1 == halt_after)) begin
                cpu_halted <= 1'b1;
                mem[121]   <= mem[120] + 32'd45;
            end
        end
        we_cnt <= we_cnt + (mem_we ? 1 : 0);
        re_cnt <= re_cnt + (mem_re ? 1 : 0);
        if (mem_we && mem_re) both_cnt <= both_cnt + 1;
    end

`ifdef MIPS_SEQ_REG_INIT_EN
    int rinit_next = 0, rinit_bad = 0, reg_cnt = 0;
    always @(posedge clk1) begin
        if (!busy) begin
            rinit_next <= 0;
        end else if (reg_we) begin
            if ((int'(reg_addr) != rinit_next) || (reg_wdata != DATA_W'(rinit_next)))
                rinit_bad <= rinit_bad + 1;
            rinit_next <= rinit_next + 1;
            reg_cnt    <= reg_cnt + 1;
        end
        if (mem_we && (rinit_next != 31)) rinit_bad <= rinit_bad + 1;
    end
`endif

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_image(input logic [31:0] d120);
        logic [31:0] prog [8];
        prog = '{32'h2801_0078, 32'h0c63_1800, 32'h2022_0000, 32'h0c63_1800,
                 32'h2842_002d, 32'h0c63_1800, 32'h2422_0001, 32'hfc00_0000};
        for (int k = 0; k < 8; k++) begin
            img_addr_tbl[k] = ADDR_W'(k);
            img_data_tbl[k] = prog[k];
        end
        img_addr_tbl[8] = ADDR_W'(120);
        img_data_tbl[8] = d120;
    endtask

    task automatic set_checks(input int a0, input logic [31:0] e0, input int a1, input logic [31:0] e1);
        chk_addr_tbl[0] = ADDR_W'(a0);
        chk_exp_tbl[0]  = e0;
        chk_addr_tbl[1] = ADDR_W'(a1);
        chk_exp_tbl[1]  = e1;
    endtask

    // One full sequence from a negedge: start pulse, bounded wait, then
    // compare every result against the reference outcome.
    task automatic do_run(input bit h_en, input int h_after, input bit inject, input string tag);
        logic [31:0] ref_mem [int];
        bit  exp_to;
        int  exp_run, exp_fail, exp_first, exp_lat;
        int  we0, re0, lat;
        bit  seen_run, prev_re;
`ifdef MIPS_SEQ_REG_INIT_EN
        int  rc0;
        rc0 = reg_cnt;
`endif
        // Reference: final memory image from the program's net effect.
        exp_to  = !(h_en && (h_after + 1 <= TIMEOUT_CYC));
        exp_run = exp_to ? TIMEOUT_CYC : h_after + 1;
        for (int k = 0; k < PROG_WORDS; k++) ref_mem[int'(img_addr_tbl[k])] = img_data_tbl[k];
        ref_mem[121] = ref_mem[120] + 32'd45;
        exp_fail = 0;
        exp_first = 0;
        if (!exp_to) begin
            for (int k = 0; k < CHECK_WORDS; k++) begin
                if (ref_mem[int'(chk_addr_tbl[k])] !== chk_exp_tbl[k]) begin
                    if (exp_fail == 0) exp_first = int'(chk_addr_tbl[k]);
                    exp_fail++;
                end
            end
        end
        exp_lat = 1 + c_RINIT + PROG_WORDS + exp_run + (exp_to ? 0 : 2 * CHECK_WORDS);

        halt_en    = h_en;
        halt_after = h_after;
        @(negedge clk1);
        we0 = we_cnt;
        re0 = re_cnt;
        start = 1'b1;
        lat = 0;
        seen_run = 1'b0;
        prev_re  = 1'b0;
        while (lat < 400) begin
            @(negedge clk1);
            lat++;
            start = 1'b0;
            if (lat == 1) begin
                check({tag, "_clr_busy"}, busy, 1);
                check({tag, "_clr_done"}, done, 0);
                check({tag, "_clr_tmo"},  timeout, 0);
                check({tag, "_clr_fail"}, fail_count, 0);
                check({tag, "_clr_run"},  run_cycles, 0);
            end
            if (done) break;
            if (inject) begin
                if (cpu_run && !seen_run) begin
                    start = 1'b1;
                    seen_run = 1'b1;
                end else if (prev_re) begin
                    start = 1'b1;
                end
            end
            prev_re = mem_re;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_done"},    done, 1);
        check({tag, "_busy"},    busy, 0);
        check({tag, "_pass"},    pass, (!exp_to && exp_fail == 0));
        check({tag, "_timeout"}, timeout, exp_to);
        check({tag, "_fails"},   fail_count, exp_fail);
        check({tag, "_first"},   first_fail_addr, exp_first);
        check({tag, "_runcyc"},  run_cycles, exp_run);
        check({tag, "_we_n"},    we_cnt - we0, PROG_WORDS);
        check({tag, "_re_n"},    re_cnt - re0, exp_to ? 0 : CHECK_WORDS);
        check({tag, "_cpu_run"}, cpu_run, 0);
`ifdef MIPS_SEQ_REG_INIT_EN
        check({tag, "_reg_n"},   reg_cnt - rc0, 31);
        check({tag, "_reg_ord"}, rinit_bad, 0);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        int rh;
        bit ren;
        set_image(32'd85);
        set_checks(121, 32'd130, 120, 32'd85);
        repeat (3) @(negedge clk1);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_pass",  pass, 0);
        check("rst_tmo",   timeout, 0);
        check("rst_fails", fail_count, 0);
        check("rst_first", first_fail_addr, 0);
        check("rst_run",   run_cycles, 0);
        check("rst_strb",  {mem_we, mem_re, cpu_run}, 0);
        rst_n = 1'b1;

        do_run(1'b1, 20, 1'b0, "pass");
        set_checks(121, 32'd131, 120, 32'd85);
        do_run(1'b1, 20, 1'b0, "fail");
        set_checks(121, 32'd130, 120, 32'd85);
        do_run(1'b0, 0, 1'b0, "tmo");
        do_run(1'b1, TIMEOUT_CYC - 1, 1'b0, "halt_at_limit");
        do_run(1'b1, TIMEOUT_CYC, 1'b0, "halt_after_limit");

        // Asynchronous reset in the third LOAD cycle
        @(negedge clk1);
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        repeat (2 + c_RINIT) @(negedge clk1);
        check("mid_we",  mem_we, 1);
        check("mid_idx", img_idx, 2);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outs", {mem_we, mem_re, cpu_run, busy, done, pass, timeout}, 0);
        check("arst_cnts", {fail_count, first_fail_addr, run_cycles, img_idx}, 0);
        @(negedge clk1);
        rst_n = 1'b1;
        do_run(1'b1, 7, 1'b0, "after_rst");

        // Start pulses during RUN and CHK_CMP are ignored
        do_run(1'b1, 12, 1'b1, "inject");

        // Randomized sequences
        for (int i = 0; i < 8; i++) begin
            rd  = $urandom;
            rh  = $urandom_range(1, TIMEOUT_CYC + 5);
            ren = ($urandom_range(0, 7) != 0);
            set_image(rd);
            set_checks(121, rd + 32'd45 + (($urandom_range(0, 2) == 0) ? 32'd1 : 32'd0),
                       120, rd ^ (($urandom_range(0, 2) == 0) ? 32'h10 : 32'h0));
            do_run(ren, rh, 1'b0, $sformatf("rnd%0d", i));
        end

        check("strobe_excl", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
